serial_adder: RTL



---
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master drives operands and out_ready; the slave returns the result side.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: one DIGIT-bit ripple slice per cycle, LSB digit first.
// Subtraction is a + ~b + 1; the result is held until the next operation completes.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave io_bus
);
   localparam int NSTEP = WIDTH / DIGIT;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;
   logic             r_cout;
   logic             r_ovf;
   logic             r_msb_a;
   logic             r_msb_b;
   logic [CW-1:0]    r_cnt;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;
   logic             w_accept;
   logic             w_last;
   logic [DIGIT:0]   w_dsum;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_acc_next;

   assign w_b_eff  = io_bus.b ^ {WIDTH{io_bus.sub}};
   assign w_accept = io_bus.in_valid && w_in_ready;
   assign w_last   = (r_cnt == CW'(NSTEP - 1));
   assign w_dsum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};

   // New digit enters at the top; the accumulator shifts toward the LSB.
   if (DIGIT == WIDTH) begin : g_acc_full
      assign w_acc_next = w_dsum[DIGIT-1:0];
   end else begin : g_acc_shift
      assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = ST_RUN;
            else          w_state_next = ST_IDLE;
         end
         ST_RUN: begin
            if (w_last) w_state_next = ST_DONE;
            else        w_state_next = ST_RUN;
         end
         ST_DONE: begin
            if (io_bus.out_ready && io_bus.in_valid) w_state_next = ST_RUN;
            else if (io_bus.out_ready)               w_state_next = ST_IDLE;
            else                                     w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE: w_in_ready = 1'b1;
         ST_RUN:  w_busy     = 1'b1;
         ST_DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = io_bus.out_ready;
         end
         default: w_in_ready = 1'b0;
      endcase
   end

   // Operand capture, digit iteration and result latching
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_c     <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_msb_a <= 1'b0;
         r_msb_b <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= io_bus.a;
         r_b     <= w_b_eff;
         r_c     <= io_bus.sub ? 1'b1 : io_bus.cin;
         r_msb_a <= io_bus.a[WIDTH-1];
         r_msb_b <= w_b_eff[WIDTH-1];
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a   <= r_a >> DIGIT;
         r_b   <= r_b >> DIGIT;
         r_acc <= w_acc_next;
         r_c   <= w_dsum[DIGIT];
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_dsum[DIGIT];
            r_ovf  <= (r_msb_a == r_msb_b) && (w_acc_next[WIDTH-1] != r_msb_a);
         end else begin
            r_sum  <= r_sum;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = w_out_valid;
   assign io_bus.busy      = w_busy;
   assign io_bus.sum       = r_sum;
   assign io_bus.cout      = r_cout;
   assign io_bus.ovf       = r_ovf;
endmodule
